adc_spi_responder: RTL and testbench

- Synthesizable responder for the 4-wire ADC serial interface driven by the IMU depth path (ADC_CS_N, ADC_SADDR, ADC_SCLK, ADC_SDAT).
- Emulates an 8-channel, 12-bit serial ADC for hardware-in-the-loop and bench use.
- Channel values are loaded from a host-side write port.
- The block plugs in where the physical ADC sits, so the depth acquisition chain can be exercised with known sample values.

---
 rtl/adc_spi_responder.sv | 158 +++++++++++++++
 tb/tb_adc_spi_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder.sv
// Emulated 8-channel serial ADC: answers 16-bit frames on ADC_SDAT with the
// value of the channel addressed in the previous complete frame.
module adc_spi_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int DATA_BITS   = 12
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 ADC_CS_N,
   input  logic                 ADC_SADDR,
   input  logic                 ADC_SCLK,
   output logic                 ADC_SDAT,
   input  logic                 ch_wr_en,
   input  logic [2:0]           ch_wr_addr,
   input  logic [DATA_BITS-1:0] ch_wr_data,
   output logic                 frame_done,
   output logic [2:0]           last_addr,
   output logic [15:0]          frame_count
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   logic [SYNC_STAGES-1:0] cs_sync_q, saddr_sync_q, sclk_sync_q;
   logic                   cs_s, saddr_s, sclk_s;
   logic                   cs_prev_q, sclk_prev_q;
   logic                   cs_fall, sclk_rise, sclk_fall;

   state_t                 state_q, state_d;
   logic [3:0]             rise_cnt_q, rise_cnt_d;
   logic [3:0]             fall_cnt_q, fall_cnt_d;
   logic [15:0]            shift_q, shift_d;
   logic [2:0]             addr_cap_q, addr_cap_d;
   logic [2:0]             next_addr_q, next_addr_d;
   logic [2:0]             last_addr_q, last_addr_d;
   logic [15:0]            frame_count_q, frame_count_d;
   logic                   frame_done_q, frame_done_d;
   logic [DATA_BITS-1:0]   ch_q [8];
   logic [15:0]            load_word;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cs_sync_q    <= '1;
         saddr_sync_q <= '0;
         sclk_sync_q  <= '0;
         cs_prev_q    <= 1'b1;
         sclk_prev_q  <= 1'b0;
      end else begin
         cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], ADC_CS_N};
         saddr_sync_q <= {saddr_sync_q[SYNC_STAGES-2:0], ADC_SADDR};
         sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], ADC_SCLK};
         cs_prev_q    <= cs_sync_q[SYNC_STAGES-1];
         sclk_prev_q  <= sclk_sync_q[SYNC_STAGES-1];
      end
   end

   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign saddr_s   = saddr_sync_q[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_fall   = cs_prev_q & ~cs_s;
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;

   // Bank is read before this clk's write lands, so a same-clk load sees the old value.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) ch_q[i] <= '0;
      end else if (ch_wr_en) begin
         ch_q[ch_wr_addr] <= ch_wr_data;
      end
   end

   assign load_word = 16'(ch_q[next_addr_q]);

   always_comb begin
      state_d       = state_q;
      rise_cnt_d    = rise_cnt_q;
      fall_cnt_d    = fall_cnt_q;
      shift_d       = shift_q;
      addr_cap_d    = addr_cap_q;
      next_addr_d   = next_addr_q;
      last_addr_d   = last_addr_q;
      frame_count_d = frame_count_q;
      frame_done_d  = 1'b0;

      if (cs_s) begin
         state_d    = IDLE;
         rise_cnt_d = '0;
         fall_cnt_d = '0;
         addr_cap_d = '0;
      end else if (state_q == IDLE) begin
         if (cs_fall) begin
            state_d    = ACTIVE;
            shift_d    = load_word;
            rise_cnt_d = '0;
            fall_cnt_d = '0;
            addr_cap_d = '0;
         end
      end else begin
         if (sclk_rise) begin
            case (rise_cnt_q)
               4'd2:    addr_cap_d[2] = saddr_s;
               4'd3:    addr_cap_d[1] = saddr_s;
               4'd4:    addr_cap_d[0] = saddr_s;
               default: ;
            endcase
            if (rise_cnt_q == 4'd15) begin
               next_addr_d   = addr_cap_q;
               last_addr_d   = addr_cap_q;
               frame_done_d  = 1'b1;
               frame_count_d = frame_count_q + 16'd1;
               rise_cnt_d    = '0;
            end else begin
               rise_cnt_d = rise_cnt_q + 4'd1;
            end
         end
         // The 16th fall always follows the 16th rise, so next_addr_q is already updated.
         if (sclk_fall) begin
            if (fall_cnt_q == 4'd15) begin
               shift_d    = load_word;
               fall_cnt_d = '0;
            end else begin
               shift_d    = {shift_q[14:0], 1'b0};
               fall_cnt_d = fall_cnt_q + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         rise_cnt_q    <= '0;
         fall_cnt_q    <= '0;
         shift_q       <= '0;
         addr_cap_q    <= '0;
         next_addr_q   <= '0;
         last_addr_q   <= '0;
         frame_count_q <= '0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         rise_cnt_q    <= rise_cnt_d;
         fall_cnt_q    <= fall_cnt_d;
         shift_q       <= shift_d;
         addr_cap_q    <= addr_cap_d;
         next_addr_q   <= next_addr_d;
         last_addr_q   <= last_addr_d;
         frame_count_q <= frame_count_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign ADC_SDAT    = (state_q == ACTIVE) & shift_q[15];
   assign frame_done  = frame_done_q;
   assign last_addr   = last_addr_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Randomized bench for adc_spi_responder: a channel-bank model predicts each
// frame's word, address and count; a monitor checks them on frame_done.
module tb_adc_spi_responder;

   localparam int HALF = 5;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ADC_CS_N, ADC_SADDR, ADC_SCLK;
   logic        ADC_SDAT;
   logic        ch_wr_en;
   logic [2:0]  ch_wr_addr;
   logic [11:0] ch_wr_data;
   logic        frame_done;
   logic [2:0]  last_addr;
   logic [15:0] frame_count;

   adc_spi_responder #(.SYNC_STAGES(2), .DATA_BITS(12)) dut (
      .clk(clk), .reset_n(reset_n),
      .ADC_CS_N(ADC_CS_N), .ADC_SADDR(ADC_SADDR), .ADC_SCLK(ADC_SCLK),
      .ADC_SDAT(ADC_SDAT),
      .ch_wr_en(ch_wr_en), .ch_wr_addr(ch_wr_addr), .ch_wr_data(ch_wr_data),
      .frame_done(frame_done), .last_addr(last_addr), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] word;
      logic [2:0]  addr;
      logic [15:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          passes = 0;
   logic [15:0] rx = '0;

   // Reference model of the emulated ADC
   logic [11:0] m_ch [8];
   logic [2:0]  m_next;
   logic [15:0] m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(posedge ADC_SCLK) if (!ADC_CS_N) rx <= {rx[14:0], ADC_SDAT};

   always @(negedge clk) begin
      if (reset_n === 1'b1 && frame_done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_frame_done: got pulse expected none (count %0d)", frame_count);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("frame_word", rx, e.word);
            chk("last_addr", last_addr, e.addr);
            chk("frame_count", frame_count, e.cnt);
         end
      end
   end

   task automatic half();
      repeat (HALF) @(negedge clk);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_ch[i] = '0;
      m_next = '0;
      m_cnt  = '0;
   endtask

   task automatic write_ch(input logic [2:0] a, input logic [11:0] d);
      @(negedge clk);
      ch_wr_en = 1'b1; ch_wr_addr = a; ch_wr_data = d;
      @(negedge clk);
      ch_wr_en = 1'b0;
      m_ch[a] = d;
   endtask

   task automatic start_cs();
      @(negedge clk);
      ADC_CS_N = 1'b0;
      half();
   endtask

   task automatic end_cs();
      half();
      ADC_CS_N = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic clock_bits(input logic [2:0] addr, input int nbits, input int wr_at,
                             input logic [2:0] wa, input logic [11:0] wd);
      for (int i = 0; i < nbits; i++) begin
         case (i)
            2:       ADC_SADDR = addr[2];
            3:       ADC_SADDR = addr[1];
            4:       ADC_SADDR = addr[0];
            default: ADC_SADDR = 1'($urandom_range(0, 1));
         endcase
         if (i == wr_at) write_ch(wa, wd);
         half();
         ADC_SCLK = 1'b1;
         half();
         ADC_SCLK = 1'b0;
      end
   endtask

   task automatic full_frame(input logic [2:0] addr, input int wr_at,
                             input logic [2:0] wa, input logic [11:0] wd);
      exp_t e;
      e.word = {4'b0000, m_ch[m_next]};
      e.addr = addr;
      e.cnt  = m_cnt + 16'd1;
      exp_q.push_back(e);
      clock_bits(addr, 16, wr_at, wa, wd);
      m_next = addr;
      m_cnt  = m_cnt + 16'd1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0; ADC_CS_N = 1'b1; ADC_SADDR = 1'b0; ADC_SCLK = 1'b0;
      ch_wr_en = 1'b0; ch_wr_addr = '0; ch_wr_data = '0;
      model_reset();
      repeat (4) @(negedge clk);
      chk("reset_sdat", ADC_SDAT, 0);
      chk("reset_frame_done", frame_done, 0);
      chk("reset_last_addr", last_addr, 0);
      chk("reset_frame_count", frame_count, 0);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      // Basic frame and address sequencing
      write_ch(3'd0, 12'hABC);
      start_cs(); full_frame(3'd5, -1, 3'd0, 12'h0); end_cs();
      write_ch(3'd5, 12'h123);
      start_cs(); full_frame(3'd2, -1, 3'd0, 12'h0); end_cs();

      // Back-to-back frames with CS held low
      write_ch(3'd1, 12'h111);
      write_ch(3'd7, 12'h777);
      start_cs();
      full_frame(3'd1, -1, 3'd0, 12'h0);
      full_frame(3'd7, -1, 3'd0, 12'h0);
      full_frame(3'd3, -1, 3'd0, 12'h0);
      end_cs();

      // Abort after 9 SCLKs
      write_ch(3'd3, 12'h3C5);
      start_cs(); clock_bits(3'd6, 9, -1, 3'd0, 12'h0);
      @(negedge clk); ADC_CS_N = 1'b1; repeat (10) @(negedge clk);
      chk("abort_frame_count", frame_count, m_cnt);
      chk("abort_sdat", ADC_SDAT, 0);
      chk("abort_last_addr", last_addr, m_next);
      start_cs(); full_frame(3'd4, -1, 3'd0, 12'h0); end_cs();

      // Mid-frame overwrite of the channel in flight
      write_ch(3'd4, 12'h0F0);
      start_cs();
      full_frame(3'd4, 7, 3'd4, 12'hF0F);
      full_frame(3'd0, -1, 3'd0, 12'h0);
      end_cs();

      // Reset pulse mid-frame
      write_ch(3'd0, 12'h5A5);
      start_cs(); clock_bits(3'd2, 6, -1, 3'd0, 12'h0);
      @(negedge clk); reset_n = 1'b0;
      @(negedge clk); reset_n = 1'b1;
      chk("midreset_sdat", ADC_SDAT, 0);
      chk("midreset_frame_count", frame_count, 0);
      chk("midreset_last_addr", last_addr, 0);
      ADC_CS_N = 1'b1;
      model_reset();
      repeat (10) @(negedge clk);
      start_cs(); full_frame(3'd6, -1, 3'd0, 12'h0); end_cs();

      // Randomized traffic
      for (int it = 0; it < 14; it++) begin
         int nw, nf;
         nw = $urandom_range(0, 3);
         for (int k = 0; k < nw; k++)
            write_ch(3'($urandom_range(0, 7)), 12'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            start_cs();
            clock_bits(3'($urandom_range(0, 7)), $urandom_range(1, 15), -1, 3'd0, 12'h0);
            @(negedge clk); ADC_CS_N = 1'b1; repeat (10) @(negedge clk);
            chk("rand_abort_count", frame_count, m_cnt);
         end
         nf = $urandom_range(1, 3);
         start_cs();
         for (int f = 0; f < nf; f++) begin
            if ($urandom_range(0, 2) == 0)
               full_frame(3'($urandom_range(0, 7)), $urandom_range(6, 14),
                          3'($urandom_range(0, 7)), 12'($urandom));
            else
               full_frame(3'($urandom_range(0, 7)), -1, 3'd0, 12'h0);
         end
         end_cs();
      end

      repeat (20) @(negedge clk);
      chk("pending_frames", exp_q.size(), 0);
      chk("final_frame_count", frame_count, m_cnt);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
